// File: rtl/button_event_classifier_pkg.sv
// rtl/button_event_classifier_pkg.sv - shared state encodings and helpers for the button event classifier
//
// Purpose: state encodings (3-bit, stable so debug displays in other labs can
// decode them) and a small helper used to size the dwell counter.
package button_event_classifier_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESSED   = 3'd1,
        S_LONG_HELD = 3'd2,
        S_WAIT_2ND  = 3'd3,
        S_PRESSED_2 = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - armed rise/fall detector for a clk-synchronous level
//
// Purpose: combinational rise/fall strobes relative to the previous sample.
// The first clock after reset only captures the level (armed goes high), so a
// level held through reset never produces a spurious edge.
// Ports:
//   clk   in  1  rising-edge clock
//   rst_n in  1  asynchronous active-low reset
//   din   in  1  synchronous level
//   rise  out 1  din is 1 now and was 0 on the previous sample
//   fall  out 1  din is 0 now and was 1 on the previous sample
module edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic prev;
    logic armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= din;
            armed <= 1'b1;
        end
    end

    assign rise = armed &  din & ~prev;
    assign fall = armed & ~din &  prev;

endmodule

// File: rtl/button_event_classifier.sv
// rtl/button_event_classifier.sv - turns a debounced button level into press/release/short/long/double-click pulses
//
// Purpose: raw edge pulses plus one classification per press sequence.
// Every output is registered: a pulse appears for exactly one cycle, one
// clock after the sample that caused it.
// Ports:
//   clk           in  1  system clock, rising edge
//   rst_n         in  1  asynchronous active-low reset
//   button_state  in  1  debounced, synchronous level, 1 = pressed
//   press_edge    out 1  pulse on 0->1
//   release_edge  out 1  pulse on 1->0
//   short_press   out 1  pulse: released before long, no second press in window
//   long_press    out 1  pulse: LONG_CYCLES-th consecutive high sample
//   double_click  out 1  pulse: second press within DBL_CYCLES low samples
//   busy          out 1  FSM not idle
module button_event_classifier
    import button_event_classifier_pkg::*;
#(
    parameter int LONG_CYCLES = 50_000_000,
    parameter int DBL_CYCLES  = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_state,
    output logic press_edge,
    output logic release_edge,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    localparam int CW = $clog2(max_int(LONG_CYCLES, DBL_CYCLES) + 1);

    // The entry sample already counts as 1, so the threshold sample is the
    // one seen while the counter holds N-1.
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    logic             rise;
    logic             fall;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;

    edge_detector u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (button_state),
        .rise  (rise),
        .fall  (fall)
    );

    // Saturating increment: the counter must never wrap back under a threshold.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            press_edge   <= 1'b0;
            release_edge <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
        end else begin
            press_edge   <= rise;
            release_edge <= fall;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state <= S_PRESSED;
                        cnt   <= CNT_ONE;
                    end
                end

                // Release is checked first so a fall on the threshold
                // sample is treated as a short press.
                S_PRESSED: begin
                    if (fall) begin
                        state <= S_WAIT_2ND;
                        cnt   <= CNT_ONE;
                    end else if (cnt >= LONG_LAST) begin
                        long_press <= 1'b1;
                        state      <= S_LONG_HELD;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                S_LONG_HELD: begin
                    if (fall) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end

                // A second press on the would-be timeout sample still counts
                // as a double click.
                S_WAIT_2ND: begin
                    if (rise) begin
                        double_click <= 1'b1;
                        state        <= S_PRESSED_2;
                        cnt          <= '0;
                    end else if (cnt >= DBL_LAST) begin
                        short_press <= 1'b1;
                        state       <= S_IDLE;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                S_PRESSED_2: begin
                    if (fall) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_classifier.sv
// tb/tb_button_event_classifier.sv - self-checking bench for button_event_classifier
module tb_button_event_classifier;

    localparam int LONG_CYCLES = 8;
    localparam int DBL_CYCLES  = 5;

    localparam int EV_NONE    = 0;
    localparam int EV_PRESS   = 1;
    localparam int EV_RELEASE = 2;
    localparam int EV_SHORT   = 3;
    localparam int EV_LONG    = 4;
    localparam int EV_DBL     = 5;

    logic clk          = 1'b0;
    logic rst_n        = 1'b0;
    logic button_state = 1'b0;
    logic press_edge;
    logic release_edge;
    logic short_press;
    logic long_press;
    logic double_click;
    logic busy;

    always #10 clk = ~clk;

    button_event_classifier #(
        .LONG_CYCLES (LONG_CYCLES),
        .DBL_CYCLES  (DBL_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .button_state (button_state),
        .press_edge   (press_edge),
        .release_edge (release_edge),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .busy         (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    typedef struct {
        int h1;
        int l1;
        int h2;
        int l2;
        int k1;
        int a1;
        int k2;
        int a2;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[11];

    int   tests = 0;
    int   fails = 0;
    int   smp   = 0;
    logic armed_m = 1'b0;
    logic prev_m  = 1'b0;

    function automatic string ev_name(input int k);
        case (k)
            EV_PRESS:   return "press_edge";
            EV_RELEASE: return "release_edge";
            EV_SHORT:   return "short_press";
            EV_LONG:    return "long_press";
            EV_DBL:     return "double_click";
            default:    return "none";
        endcase
    endfunction

    task automatic push_exp(input int k, input int c);
        exp_t e;
        e.kind = k;
        e.at   = c;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One input sample: drive mid-cycle, predict raw edges for the sample
    // taken at the next rising edge.
    task automatic step(input logic v);
        @(posedge clk);
        #5;
        button_state = v;
        smp = cyc + 1;
        if (!armed_m) begin
            armed_m = 1'b1;
        end else begin
            if (v && !prev_m) push_exp(EV_PRESS, smp);
            if (!v && prev_m) push_exp(EV_RELEASE, smp);
        end
        prev_m = v;
    endtask

    // Classification sample indices are 1-based from the first sample.
    task automatic run_pattern(input vec_t v);
        int n;
        int base;
        int cnts[4];
        logic vals[4];
        n = 0;
        base = 0;
        cnts[0] = v.h1; cnts[1] = v.l1; cnts[2] = v.h2; cnts[3] = v.l2;
        vals[0] = 1'b1; vals[1] = 1'b0; vals[2] = 1'b1; vals[3] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < cnts[s]; j++) begin
                step(vals[s]);
                n++;
                if (n == 1) begin
                    base = smp;
                    if (v.k1 != EV_NONE) push_exp(v.k1, base + v.a1 - 1);
                    if (v.k2 != EV_NONE) push_exp(v.k2, base + v.a2 - 1);
                end
            end
        end
    endtask

    task automatic monitor_step();
        logic [5:1] seen;
        int idx;
        seen = {double_click, long_press, short_press, release_edge, press_edge};
        for (int k = 1; k <= 5; k++) begin
            if (seen[k]) begin
                idx = -1;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (exp_q[i].kind == k && exp_q[i].at == cyc) begin
                        idx = i;
                        break;
                    end
                end
                tests++;
                if (idx < 0) begin
                    fails++;
                    $display("FAIL unexpected_%s: got pulse at cycle %0d, required none", ev_name(k), cyc);
                end else begin
                    exp_q.delete(idx);
                end
            end
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at <= cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_%s: got no pulse, required at cycle %0d", ev_name(exp_q[i].kind), exp_q[i].at);
                exp_q.delete(i);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_press_edge"},   int'(press_edge),   0);
        check({tag, "_release_edge"}, int'(release_edge), 0);
        check({tag, "_short_press"},  int'(short_press),  0);
        check({tag, "_long_press"},   int'(long_press),   0);
        check({tag, "_double_click"}, int'(double_click), 0);
        check({tag, "_busy"},         int'(busy),         0);
    endtask

    task automatic run_all();
        int r;
        // Reset state
        repeat (3) @(posedge clk);
        #5;
        check_all_zero("reset");
        rst_n = 1'b1;
        armed_m = 1'b0;
        step(1'b0);
        step(1'b0);

        // Table vectors
        for (int i = 0; i < 11; i++) run_pattern(vecs[i]);

        // Long press with busy tracking
        @(negedge clk);
        check("busy_idle", int'(busy), 0);
        step(1'b1);
        push_exp(EV_LONG, smp + 7);
        @(negedge clk);
        @(negedge clk);
        check("busy_pressed", int'(busy), 1);
        repeat (11) step(1'b1);
        step(1'b0);
        @(negedge clk);
        check("busy_long_held", int'(busy), 1);
        @(negedge clk);
        check("busy_after_fall", int'(busy), 0);
        repeat (6) step(1'b0);

        // Async reset in WAIT_2ND, released with the button held
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        button_state = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #5;
        rst_n = 1'b1;
        armed_m = 1'b0;
        step(1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        r = smp;
        push_exp(EV_SHORT, r + 6);
        step(1'b1);
        repeat (8) step(1'b0);

        repeat (4) step(1'b0);
    endtask

    initial begin
        //           h1  l1  h2  l2  k1        a1  k2        a2
        vecs[0]  = '{3,  10, 0,  0,  EV_SHORT, 8,  EV_NONE,  0};
        vecs[1]  = '{12, 6,  0,  0,  EV_LONG,  8,  EV_NONE,  0};
        vecs[2]  = '{2,  3,  2,  10, EV_DBL,   6,  EV_NONE,  0};
        vecs[3]  = '{2,  4,  2,  8,  EV_DBL,   7,  EV_NONE,  0};
        vecs[4]  = '{2,  5,  3,  10, EV_SHORT, 7,  EV_SHORT, 15};
        vecs[5]  = '{7,  8,  0,  0,  EV_SHORT, 12, EV_NONE,  0};
        vecs[6]  = '{8,  6,  0,  0,  EV_LONG,  8,  EV_NONE,  0};
        vecs[7]  = '{1,  6,  0,  0,  EV_SHORT, 6,  EV_NONE,  0};
        vecs[8]  = '{2,  1,  1,  6,  EV_DBL,   4,  EV_NONE,  0};
        vecs[9]  = '{9,  2,  4,  6,  EV_LONG,  8,  EV_SHORT, 20};
        vecs[10] = '{1,  2,  12, 6,  EV_DBL,   4,  EV_NONE,  0};

        fork
            begin
                forever begin
                    @(negedge clk);
                    monitor_step();
                end
            end
            begin
                run_all();
            end
            begin
                repeat (5000) @(posedge clk);
                tests++;
                fails++;
                $display("FAIL watchdog: got no completion, required finish within 5000 cycles");
            end
        join_any
        disable fork;

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
